pbus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the memory-mapped peripheral bus (the `0xC0000000`–`0xFFFFFFFF` p-port). It shares one peripheral slave port between master 0 (the CPU p-port, with a stall-capable wrapper) and master 1 (DMA/debug). It round-robins between them, runs a req/ack handshake to the slave, and terminates hung accesses with a bus-error timeout.

---
 rtl/pbus_arbiter.sv | 151 +++++++++++++++
 tb/tb_pbus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_arbiter.sv
// rtl/pbus_arbiter.sv - two-master round-robin arbiter and sequencer for the peripheral bus
//
// Shares one peripheral slave port between master 0 (CPU p-port) and
// master 1 (DMA/debug). It arbitrates in IDLE, drives a req/ack handshake in
// ACCESS and reports the result in DONE. If the slave does not ack within
// TIMEOUT ACCESS cycles, the access ends with a bus error.
//
// Ports:
//   clock, reset                      single clock, async active-high reset
//   mN_addr/wdata/size                requester transaction fields
//   mN_rd_req/wr_req                  level requests, held until done
//   mN_rdata                          registered read result
//   mN_done, mN_err                   one-cycle completion pulse and error flag
//   s_addr/wdata/size                 latched fields to the slave
//   s_rd_req/s_wr_req                 slave strobes, high only in ACCESS
//   s_rdata, s_ack                    slave read data and completion
module pbus_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_size,
  input  logic        m0_rd_req,
  input  logic        m0_wr_req,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_size,
  input  logic        m1_rd_req,
  input  logic        m1_wr_req,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [2:0]  s_size,
  output logic        s_rd_req,
  output logic        s_wr_req,
  input  logic [31:0] s_rdata,
  input  logic        s_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic       g;        // granted master index
  logic       last;     // master granted most recently
  logic       lat_rd;   // latched access type: 1 = read (also when both strobes high)
  logic       err_q;
  logic [7:0] cnt;

  logic req0;
  logic req1;
  logic grant;
  logic timed_out;

  assign req0 = m0_rd_req | m0_wr_req;
  assign req1 = m1_rd_req | m1_wr_req;

  // On a tie the master that did not win last time gets the bus.
  assign grant     = (req0 && req1) ? ~last : req1;
  assign timed_out = (cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0 || req1) state_next = ACCESS;
      ACCESS:  if (s_ack || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      g        <= 1'b0;
      last     <= 1'b1;
      lat_rd   <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= 8'd0;
      s_addr   <= 32'd0;
      s_wdata  <= 32'd0;
      s_size   <= 3'd0;
      m0_rdata <= 32'd0;
      m1_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            g       <= grant;
            s_addr  <= grant ? m1_addr  : m0_addr;
            s_wdata <= grant ? m1_wdata : m0_wdata;
            s_size  <= grant ? m1_size  : m0_size;
            lat_rd  <= grant ? m1_rd_req : m0_rd_req;
            cnt     <= 8'd0;
          end
        end
        ACCESS: begin
          // Ack takes priority over the timeout on the same cycle.
          if (s_ack) begin
            err_q <= 1'b0;
            if (lat_rd) begin
              if (g) m1_rdata <= s_rdata;
              else   m0_rdata <= s_rdata;
            end
          end else if (timed_out) begin
            err_q <= 1'b1;
            if (lat_rd) begin
              if (g) m1_rdata <= 32'hFFFF_FFFF;
              else   m0_rdata <= 32'hFFFF_FFFF;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          last <= g;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state and registers only; nothing combinational from s_ack or requests.
  assign s_rd_req = (state == ACCESS) &&  lat_rd;
  assign s_wr_req = (state == ACCESS) && !lat_rd;
  assign m0_done  = (state == DONE) && !g;
  assign m1_done  = (state == DONE) &&  g;
  assign m0_err   = m0_done && err_q;
  assign m1_err   = m1_done && err_q;

endmodule

// File: tb/tb_pbus_arbiter.sv
// tb/tb_pbus_arbiter.sv - scoreboard testbench for pbus_arbiter
module tb_pbus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [2:0]  m0_size = '0, m1_size = '0;
  logic        m0_rd_req = 0, m0_wr_req = 0, m1_rd_req = 0, m1_wr_req = 0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_size;
  logic        s_rd_req, s_wr_req;
  logic [31:0] s_rdata = '0;
  logic        s_ack = 1'b0;

  pbus_arbiter #(.TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_size(s_size),
    .s_rd_req(s_rd_req), .s_wr_req(s_wr_req),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        rd;
    logic        wr;
    int          len;   // strobe cycles; -1 means the access is cut by reset
    int          gap;   // cycles since previous strobe start; 0 = not checked
  } slv_exp_t;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
  } done_exp_t;

  slv_exp_t  slv_q[$];
  done_exp_t done_q[$];

  int checks = 0;
  int errors = 0;

  // Slave model: acks on the slv_lat-th ACCESS cycle (0 = never).
  int          slv_lat  = 1;
  logic [31:0] slv_data = '0;
  int          acc_cnt  = 0;

  always @(negedge clock) begin
    if (reset || !(s_rd_req || s_wr_req)) begin
      acc_cnt = 0;
      s_ack   = 1'b0;
      s_rdata = 32'hBADB_AD00;
    end else begin
      acc_cnt = acc_cnt + 1;
      s_ack   = (slv_lat != 0) && (acc_cnt == slv_lat);
      s_rdata = s_ack ? slv_data : 32'hBADB_AD00;
    end
  end

  // Monitor: compares slave-side transactions and master completions.
  int cyc = 0;
  int run = 0;
  int last_start = 0;

  always @(negedge clock) begin
    slv_exp_t  se;
    done_exp_t de;
    cyc = cyc + 1;
    if (reset) begin
      if (run > 0) begin
        checks++;
        if (slv_q.size() == 0 || slv_q[0].len != -1) begin
          errors++;
          $display("FAIL abort: access cut by reset was not expected");
        end
        if (slv_q.size() != 0) void'(slv_q.pop_front());
      end
      run = 0;
    end else if (s_rd_req || s_wr_req) begin
      if (run == 0) begin
        checks++;
        if (slv_q.size() == 0) begin
          errors++;
          $display("FAIL slv_start: unexpected access addr=%h", s_addr);
        end else begin
          se = slv_q[0];
          if ({s_addr, s_wdata, s_size, s_rd_req, s_wr_req} !==
              {se.addr, se.wdata, se.size, se.rd, se.wr}) begin
            errors++;
            $display("FAIL slv_fields: got addr=%h wdata=%h size=%b rd=%b wr=%b want addr=%h wdata=%h size=%b rd=%b wr=%b",
                     s_addr, s_wdata, s_size, s_rd_req, s_wr_req,
                     se.addr, se.wdata, se.size, se.rd, se.wr);
          end
          if (se.gap > 0) begin
            checks++;
            if (cyc - last_start != se.gap) begin
              errors++;
              $display("FAIL grant_gap: got %0d want %0d", cyc - last_start, se.gap);
            end
          end
        end
        last_start = cyc;
      end
      run = run + 1;
    end else if (run > 0) begin
      checks++;
      if (slv_q.size() == 0) begin
        errors++;
        $display("FAIL slv_len: no expectation for access of %0d cycles", run);
      end else begin
        se = slv_q.pop_front();
        if (se.len != run) begin
          errors++;
          $display("FAIL slv_len: strobe high %0d cycles want %0d", run, se.len);
        end
      end
      run = 0;
    end

    if (m0_done || m1_done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done: unexpected done m0=%b m1=%b", m0_done, m1_done);
      end else begin
        de = done_q.pop_front();
        if (de.m == 0) begin
          if ({m0_done, m1_done, m0_err, m0_rdata} !== {1'b1, 1'b0, de.err, de.rdata}) begin
            errors++;
            $display("FAIL done_m0: got done=%b/%b err=%b rdata=%h want m0 err=%b rdata=%h",
                     m0_done, m1_done, m0_err, m0_rdata, de.err, de.rdata);
          end
        end else begin
          if ({m0_done, m1_done, m1_err, m1_rdata} !== {1'b0, 1'b1, de.err, de.rdata}) begin
            errors++;
            $display("FAIL done_m1: got done=%b/%b err=%b rdata=%h want m1 err=%b rdata=%h",
                     m0_done, m1_done, m1_err, m1_rdata, de.err, de.rdata);
          end
        end
      end
    end
  end

  task automatic exp_slv(input logic [31:0] a, input logic [31:0] w, input logic [2:0] sz,
                         input logic rd, input logic wr, input int len, input int gap);
    slv_exp_t e;
    e.addr = a; e.wdata = w; e.size = sz; e.rd = rd; e.wr = wr; e.len = len; e.gap = gap;
    slv_q.push_back(e);
  endtask

  task automatic exp_done(input int m, input logic err, input logic [31:0] rd);
    done_exp_t e;
    e.m = m; e.err = err; e.rdata = rd;
    done_q.push_back(e);
  endtask

  task automatic drive(input int m, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] w, input logic [2:0] sz);
    if (m == 0) begin
      m0_addr = a; m0_wdata = w; m0_size = sz; m0_rd_req = rd; m0_wr_req = wr;
    end else begin
      m1_addr = a; m1_wdata = w; m1_size = sz; m1_rd_req = rd; m1_wr_req = wr;
    end
  endtask

  // Waits for k completions; drops each master's request in its DONE cycle
  // unless hold is set, in which case everything drops after the k-th.
  task automatic run_for(input int k, input bit hold, input int budget);
    int seen = 0;
    int n = 0;
    while (seen < k && n < budget) begin
      @(negedge clock);
      n++;
      if (m0_done || m1_done) seen++;
      if (!hold || seen == k) begin
        if (m0_done || hold) begin m0_rd_req = 0; m0_wr_req = 0; end
        if (m1_done || hold) begin m1_rd_req = 0; m1_wr_req = 0; end
      end
    end
    checks++;
    if (seen < k) begin
      errors++;
      $display("FAIL timeout_wait: saw %0d of %0d completions", seen, k);
      m0_rd_req = 0; m0_wr_req = 0; m1_rd_req = 0; m1_wr_req = 0;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_outputs_clear(input string name);
    checks++;
    if ({s_addr, s_wdata, s_size, s_rd_req, s_wr_req, m0_done, m0_err, m1_done, m1_err,
         m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL %s: s_addr=%h s_wdata=%h s_size=%b rd=%b wr=%b done=%b%b err=%b%b rdata=%h/%h want all 0",
               name, s_addr, s_wdata, s_size, s_rd_req, s_wr_req, m0_done, m1_done,
               m0_err, m1_err, m0_rdata, m1_rdata);
    end
  endtask

  initial begin
    #1;
    check_outputs_clear("reset_state");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Round-robin: both hold writes; m0 wins first tie after reset.
    slv_lat = 1;
    exp_slv(32'hC000_0000, 32'hAAAA_0000, 3'b100, 0, 1, 1, 0);
    exp_slv(32'hC000_0004, 32'h5555_FFFF, 3'b100, 0, 1, 1, 3);
    exp_slv(32'hC000_0000, 32'hAAAA_0000, 3'b100, 0, 1, 1, 3);
    exp_slv(32'hC000_0004, 32'h5555_FFFF, 3'b100, 0, 1, 1, 3);
    exp_done(0, 0, 32'h0); exp_done(1, 0, 32'h0);
    exp_done(0, 0, 32'h0); exp_done(1, 0, 32'h0);
    drive(0, 0, 1, 32'hC000_0000, 32'hAAAA_0000, 3'b100);
    drive(1, 0, 1, 32'hC000_0004, 32'h5555_FFFF, 3'b100);
    run_for(4, 1, 60);

    // Single read with wait states: ack on the 3rd ACCESS cycle.
    slv_lat = 3; slv_data = 32'h1234_5678;
    exp_slv(32'hC000_0010, 32'h0, 3'b100, 1, 0, 3, 0);
    exp_done(0, 0, 32'h1234_5678);
    drive(0, 1, 0, 32'hC000_0010, 32'h0, 3'b100);
    run_for(1, 0, 40);

    // Timeout: no ack for 15 ACCESS cycles.
    slv_lat = 0;
    exp_slv(32'hC000_0100, 32'h0, 3'b001, 1, 0, 15, 0);
    exp_done(1, 1, 32'hFFFF_FFFF);
    drive(1, 1, 0, 32'hC000_0100, 32'h0, 3'b001);
    run_for(1, 0, 60);

    // Ack on the final cycle wins over the timeout.
    slv_lat = 15; slv_data = 32'h0000_0042;
    exp_slv(32'hC000_0104, 32'h0, 3'b010, 1, 0, 15, 0);
    exp_done(1, 0, 32'h0000_0042);
    drive(1, 1, 0, 32'hC000_0104, 32'h0, 3'b010);
    run_for(1, 0, 60);

    // Both strobes high: performed as a read.
    slv_lat = 2; slv_data = 32'hCAFE_F00D;
    exp_slv(32'hC000_0020, 32'hDEAD_BEEF, 3'b001, 1, 0, 2, 0);
    exp_done(0, 0, 32'hCAFE_F00D);
    drive(0, 1, 1, 32'hC000_0020, 32'hDEAD_BEEF, 3'b001);
    run_for(1, 0, 40);

    // Reset mid-access: outputs clear before the next edge, no done.
    slv_lat = 0;
    exp_slv(32'hC000_0030, 32'h0, 3'b100, 1, 0, -1, 0);
    drive(0, 1, 0, 32'hC000_0030, 32'h0, 3'b100);
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1 check_outputs_clear("reset_mid_access");
    drive(0, 0, 0, 32'h0, 32'h0, 3'b000);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // After release, m0 wins the tie.
    slv_lat = 1; slv_data = 32'h0000_0077;
    exp_slv(32'hC000_0200, 32'h0, 3'b100, 1, 0, 1, 0);
    exp_slv(32'hC000_0300, 32'h0, 3'b100, 1, 0, 1, 3);
    exp_done(0, 0, 32'h0000_0077);
    exp_done(1, 0, 32'h0000_0077);
    drive(0, 1, 0, 32'hC000_0200, 32'h0, 3'b100);
    drive(1, 1, 0, 32'hC000_0300, 32'h0, 3'b100);
    run_for(2, 0, 40);

    checks++;
    if (slv_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: slave left %0d done left %0d want 0/0",
               slv_q.size(), done_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
